// File: rtl/ahb_slave_controller_if.sv
// AHB data-phase signals between the bus fabric and the AES slave controller.
// Handshake: a transfer completes on a rising edge where HREADY=1 and the slave drove HREADYOUT=1;
// the address phase (opcode/haddr_word) is accepted on that same edge, HWDATA/HRDATA belong to the data phase.
interface ahb_slave_controller_if;
    logic        HREADY;
    logic [3:0]  opcode;
    logic [1:0]  haddr_word;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport slave (
        input  HREADY, opcode, haddr_word, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );

    modport master (
        output HREADY, opcode, haddr_word, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_slave_controller.sv
// Data-phase sequencer for the AES accelerator AHB slave: registers the decoded opcode,
// drives FIFO/key/start strobes, inserts wait states while FIFOs block and times out to ERROR.
module ahb_slave_controller #(
    parameter int WAIT_MAX = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb_slave_controller_if.slave bus,
    input  logic                 rcv_fifo_full,
    input  logic                 rcv_fifo_empty,
    input  logic                 tx_fifo_empty,
    input  logic [31:0]          tx_rdata,
    input  logic                 core_busy,
    input  logic [7:0]           status,
    output logic                 rcv_push,
    output logic [31:0]          rcv_wdata,
    output logic                 tx_pop,
    output logic                 key_we,
    output logic [1:0]           key_idx,
    output logic [31:0]          key_wdata,
    output logic                 key_done,
    output logic                 enc_start,
    output logic                 dec_start,
    output logic [1:0]           state_dbg
);
    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_OUT      = 4'd1;
    localparam logic [3:0] OP_IN       = 4'd2;
    localparam logic [3:0] OP_KEY      = 4'd3;
    localparam logic [3:0] OP_LAST_KEY = 4'd4;
    localparam logic [3:0] OP_STATUS   = 4'd5;
    localparam logic [3:0] OP_ENC      = 4'd6;
    localparam logic [3:0] OP_DEC      = 4'd7;
    localparam logic [3:0] OP_OUT_BUSY = 4'd10;
    localparam logic [3:0] OP_IN_BUSY  = 4'd11;
    localparam logic [3:0] OP_KEY_BUSY = 4'd12;

    localparam int         CW       = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    typedef enum logic [1:0] {S_DATA, S_STALL, S_ERR1, S_ERR2} state_t;

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] wait_cnt, wait_cnt_d;
    logic          stall_clear;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= S_DATA;
            op_q     <= OP_NOP;
            idx_q    <= 2'd0;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        idx_d       = idx_q;
        wait_cnt_d  = wait_cnt;
        stall_clear = 1'b0;
        case (state_q)
            S_DATA, S_ERR2: begin
                // Both states drive HREADYOUT=1, so the next address phase is taken here.
                if (bus.HREADY) begin
                    op_d       = bus.opcode;
                    idx_d      = bus.haddr_word;
                    wait_cnt_d = '0;
                    case (bus.opcode)
                        OP_ENC, OP_DEC:                       state_d = core_busy ? S_ERR1 : S_DATA;
                        OP_OUT_BUSY, OP_IN_BUSY, OP_KEY_BUSY: state_d = S_STALL;
                        4'd9, 4'd13, 4'd14, 4'd15:            state_d = S_ERR1;
                        default:                              state_d = S_DATA;
                    endcase
                end
            end
            S_STALL: begin
                case (op_q)
                    OP_IN_BUSY:  stall_clear = !rcv_fifo_full;
                    OP_OUT_BUSY: stall_clear = !tx_fifo_empty;
                    OP_KEY_BUSY: stall_clear = rcv_fifo_empty;
                    default:     stall_clear = 1'b0;
                endcase
                // A clearing FIFO beats the timeout landing on the same cycle.
                if (stall_clear) begin
                    state_d = S_DATA;
                    case (op_q)
                        OP_IN_BUSY:  op_d = OP_IN;
                        OP_OUT_BUSY: op_d = OP_OUT;
                        default:     op_d = OP_KEY;
                    endcase
                end else begin
                    wait_cnt_d = wait_cnt + CW'(1);
                    if (wait_cnt == CNT_LAST) state_d = S_ERR1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_DATA;
        endcase
    end

    always_comb begin
        bus.HREADYOUT = 1'b1;
        bus.HRESP     = 1'b0;
        bus.HRDATA    = 32'd0;
        rcv_push      = 1'b0;
        tx_pop        = 1'b0;
        key_we        = 1'b0;
        key_done      = 1'b0;
        enc_start     = 1'b0;
        dec_start     = 1'b0;
        case (state_q)
            S_DATA: begin
                case (op_q)
                    OP_IN:  rcv_push = 1'b1;
                    OP_OUT: begin
                        tx_pop     = 1'b1;
                        bus.HRDATA = tx_rdata;
                    end
                    OP_KEY: key_we = 1'b1;
                    OP_LAST_KEY: begin
                        key_we   = 1'b1;
                        key_done = 1'b1;
                    end
                    OP_STATUS: bus.HRDATA = {24'd0, status};
                    OP_ENC:    enc_start  = 1'b1;
                    OP_DEC:    dec_start  = 1'b1;
                    default:   ;
                endcase
            end
            S_STALL: bus.HREADYOUT = 1'b0;
            S_ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = 1'b1;
            end
            default: bus.HRESP = 1'b1;
        endcase
    end

    assign rcv_wdata = bus.HWDATA;
    assign key_wdata = bus.HWDATA;
    assign key_idx   = idx_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_ahb_slave_controller.sv
// Directed, table-driven bench for ahb_slave_controller (instantiated with WAIT_MAX=4).
// Each record is one clock cycle: inputs driven in that cycle plus the output class expected in it.
module tb_ahb_slave_controller;
    localparam logic [31:0] TX_WORD = 32'h1234_5678;
    localparam logic [7:0]  STATUS  = 8'h5A;

    typedef enum int {X_IDLE, X_STALL, X_ERR1, X_ERR2, X_PUSH, X_POP,
                      X_KWE, X_KDONE, X_STAT, X_ENC, X_DEC} exp_t;

    typedef struct {
        logic        rst;
        logic        hready;
        logic [3:0]  op;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic        rfull;
        logic        rempty;
        logic        txempty;
        logic        busy;
        exp_t        ex;
        logic [1:0]  kidx;
    } vec_t;

    // clock / reset
    logic HCLK = 1'b0;
    logic HRESET;
    always #5 HCLK = ~HCLK;

    ahb_slave_controller_if bus();
    logic        rcv_fifo_full, rcv_fifo_empty, tx_fifo_empty, core_busy;
    logic [31:0] tx_rdata;
    logic [7:0]  status;
    logic        rcv_push, tx_pop, key_we, key_done, enc_start, dec_start;
    logic [31:0] rcv_wdata, key_wdata;
    logic [1:0]  key_idx, state_dbg;

    ahb_slave_controller #(.WAIT_MAX(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus),
        .rcv_fifo_full(rcv_fifo_full), .rcv_fifo_empty(rcv_fifo_empty),
        .tx_fifo_empty(tx_fifo_empty), .tx_rdata(tx_rdata),
        .core_busy(core_busy), .status(status),
        .rcv_push(rcv_push), .rcv_wdata(rcv_wdata), .tx_pop(tx_pop),
        .key_we(key_we), .key_idx(key_idx), .key_wdata(key_wdata),
        .key_done(key_done), .enc_start(enc_start), .dec_start(dec_start),
        .state_dbg(state_dbg)
    );

    // scoreboard
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    vec_t        tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic vec_t row(input logic rst, input logic hready, input logic [3:0] op,
                                 input logic [1:0] addr, input logic [31:0] wd,
                                 input logic rfull, input logic rempty, input logic txempty,
                                 input logic busy, input exp_t ex, input logic [1:0] kidx);
        vec_t v;
        v.rst = rst; v.hready = hready; v.op = op; v.addr = addr; v.wd = wd;
        v.rfull = rfull; v.rempty = rempty; v.txempty = txempty; v.busy = busy;
        v.ex = ex; v.kidx = kidx;
        return v;
    endfunction

    // driver + per-cycle check
    task automatic apply(input vec_t v, input string tag);
        logic        e_rdy, e_resp, e_push, e_pop, e_kwe, e_kdone, e_enc, e_dec;
        logic [31:0] e_rdata;
        HRESET         = v.rst;
        bus.HREADY     = v.hready;
        bus.opcode     = v.op;
        bus.haddr_word = v.addr;
        bus.HWDATA     = v.wd;
        rcv_fifo_full  = v.rfull;
        rcv_fifo_empty = v.rempty;
        tx_fifo_empty  = v.txempty;
        core_busy      = v.busy;
        #1;
        e_rdy   = !(v.ex == X_STALL || v.ex == X_ERR1);
        e_resp  = (v.ex == X_ERR1 || v.ex == X_ERR2);
        e_rdata = (v.ex == X_POP) ? TX_WORD : (v.ex == X_STAT) ? {24'd0, STATUS} : 32'd0;
        e_push  = (v.ex == X_PUSH);
        e_pop   = (v.ex == X_POP);
        e_kwe   = (v.ex == X_KWE || v.ex == X_KDONE);
        e_kdone = (v.ex == X_KDONE);
        e_enc   = (v.ex == X_ENC);
        e_dec   = (v.ex == X_DEC);
        chk({tag, ".hreadyout"}, 32'(bus.HREADYOUT), 32'(e_rdy));
        chk({tag, ".hresp"},     32'(bus.HRESP),     32'(e_resp));
        chk({tag, ".hrdata"},    bus.HRDATA,         e_rdata);
        chk({tag, ".rcv_push"},  32'(rcv_push),      32'(e_push));
        chk({tag, ".tx_pop"},    32'(tx_pop),        32'(e_pop));
        chk({tag, ".key_we"},    32'(key_we),        32'(e_kwe));
        chk({tag, ".key_done"},  32'(key_done),      32'(e_kdone));
        chk({tag, ".enc_start"}, 32'(enc_start),     32'(e_enc));
        chk({tag, ".dec_start"}, 32'(dec_start),     32'(e_dec));
        if (e_kwe) begin
            chk({tag, ".key_idx"},   32'(key_idx), 32'(v.kidx));
            chk({tag, ".key_wdata"}, key_wdata,    v.wd);
        end
        if (rcv_push) begin
            if (exp_q.size() == 0) chk({tag, ".rcv_sb_extra"}, 32'd1, 32'd0);
            else                   chk({tag, ".rcv_wdata"}, rcv_wdata, exp_q.pop_front());
        end
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        tx_rdata = TX_WORD;
        status   = STATUS;
        // reset: two cycles, not checked (state undefined before the first edge)
        HRESET = 1'b1; bus.HREADY = 1'b1; bus.opcode = 4'd0; bus.haddr_word = 2'd0;
        bus.HWDATA = 32'd0; rcv_fifo_full = 1'b0; rcv_fifo_empty = 1'b1;
        tx_fifo_empty = 1'b0; core_busy = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;

        exp_q.push_back(32'hA); exp_q.push_back(32'hB);
        exp_q.push_back(32'hC); exp_q.push_back(32'hD);
        exp_q.push_back(32'hE);

        //                rst hrdy op     addr wd     rfull remp txe busy expect   kidx
        tbl.push_back(row(0, 1, 4'd6,  0, 32'h0, 0, 1, 0, 0, X_IDLE,  0)); // reset state, ENCRYPT
        tbl.push_back(row(0, 1, 4'd0,  0, 32'h0, 0, 1, 0, 0, X_ENC,   0));
        tbl.push_back(row(0, 1, 4'd2,  0, 32'h0, 0, 1, 0, 0, X_IDLE,  0)); // INPUT_BUR x4
        tbl.push_back(row(0, 1, 4'd2,  0, 32'hA, 0, 1, 0, 0, X_PUSH,  0));
        tbl.push_back(row(0, 1, 4'd2,  0, 32'hB, 0, 1, 0, 0, X_PUSH,  0));
        tbl.push_back(row(0, 1, 4'd2,  0, 32'hC, 0, 1, 0, 0, X_PUSH,  0));
        tbl.push_back(row(0, 1, 4'd0,  0, 32'hD, 0, 1, 0, 0, X_PUSH,  0));
        tbl.push_back(row(0, 1, 4'd3,  0, 32'h0, 0, 1, 0, 0, X_IDLE,  0)); // key words 0..3
        tbl.push_back(row(0, 1, 4'd3,  1, 32'h10, 0, 1, 0, 0, X_KWE,  0));
        tbl.push_back(row(0, 1, 4'd3,  2, 32'h11, 0, 1, 0, 0, X_KWE,  1));
        tbl.push_back(row(0, 1, 4'd4,  3, 32'h12, 0, 1, 0, 0, X_KWE,  2));
        tbl.push_back(row(0, 1, 4'd5,  0, 32'h13, 0, 1, 0, 0, X_KDONE, 3));
        tbl.push_back(row(0, 1, 4'd1,  0, 32'h0, 0, 1, 0, 0, X_STAT,  0)); // status, then read
        tbl.push_back(row(0, 1, 4'd9,  0, 32'h0, 0, 1, 0, 0, X_POP,   0)); // ERROR opcode
        tbl.push_back(row(0, 0, 4'd0,  0, 32'h0, 0, 1, 0, 0, X_ERR1,  0));
        tbl.push_back(row(0, 1, 4'd7,  0, 32'h0, 0, 1, 0, 1, X_ERR2,  0)); // DECRYPT, core busy
        tbl.push_back(row(0, 0, 4'd0,  0, 32'h0, 0, 1, 0, 0, X_ERR1,  0));
        tbl.push_back(row(0, 1, 4'd7,  0, 32'h0, 0, 1, 0, 0, X_ERR2,  0)); // DECRYPT, core idle
        tbl.push_back(row(0, 1, 4'd15, 0, 32'h0, 0, 1, 0, 0, X_DEC,   0)); // reserved opcode
        tbl.push_back(row(0, 0, 4'd0,  0, 32'h0, 0, 1, 0, 0, X_ERR1,  0));
        tbl.push_back(row(0, 1, 4'd0,  0, 32'h0, 0, 1, 0, 0, X_ERR2,  0));
        tbl.push_back(row(0, 1, 4'd0,  0, 32'h0, 0, 1, 0, 0, X_IDLE,  0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // INPUT_BUR_BUSY: FIFO full until the 4th stall cycle, which is also the timeout cycle
        apply(row(0, 1, 4'd11, 0, 32'h0, 1, 1, 0, 0, X_IDLE,  0), "in_stall0");
        apply(row(0, 0, 4'd0,  0, 32'h0, 1, 1, 0, 0, X_STALL, 0), "in_stall1");
        apply(row(0, 0, 4'd0,  0, 32'h0, 1, 1, 0, 0, X_STALL, 0), "in_stall2");
        apply(row(0, 0, 4'd0,  0, 32'h0, 1, 1, 0, 0, X_STALL, 0), "in_stall3");
        apply(row(0, 0, 4'd0,  0, 32'h0, 0, 1, 0, 0, X_STALL, 0), "in_stall4");
        apply(row(0, 1, 4'd0,  0, 32'hE, 0, 1, 0, 0, X_PUSH,  0), "in_stall5");
        apply(row(0, 1, 4'd0,  0, 32'h0, 0, 1, 0, 0, X_IDLE,  0), "in_stall6");

        // OUTPUT_BUR_BUSY with the TX FIFO never filling: 4 stalls then a two-cycle ERROR
        apply(row(0, 1, 4'd10, 0, 32'h0, 0, 1, 1, 0, X_IDLE,  0), "out_to0");
        apply(row(0, 0, 4'd0,  0, 32'h0, 0, 1, 1, 0, X_STALL, 0), "out_to1");
        apply(row(0, 0, 4'd0,  0, 32'h0, 0, 1, 1, 0, X_STALL, 0), "out_to2");
        apply(row(0, 0, 4'd0,  0, 32'h0, 0, 1, 1, 0, X_STALL, 0), "out_to3");
        apply(row(0, 0, 4'd0,  0, 32'h0, 0, 1, 1, 0, X_STALL, 0), "out_to4");
        apply(row(0, 0, 4'd0,  0, 32'h0, 0, 1, 1, 0, X_ERR1,  0), "out_to5");
        apply(row(0, 1, 4'd0,  0, 32'h0, 0, 1, 1, 0, X_ERR2,  0), "out_to6");
        apply(row(0, 1, 4'd0,  0, 32'h0, 0, 1, 0, 0, X_IDLE,  0), "out_to7");

        // KEY_BUR_BUSY waits for the receive FIFO to drain, then writes word 2
        apply(row(0, 1, 4'd12, 2, 32'h0,  0, 0, 0, 0, X_IDLE,  0), "key_st0");
        apply(row(0, 0, 4'd0,  0, 32'h0,  0, 1, 0, 0, X_STALL, 0), "key_st1");
        apply(row(0, 1, 4'd0,  0, 32'h77, 0, 1, 0, 0, X_KWE,   2), "key_st2");
        apply(row(0, 1, 4'd0,  0, 32'h0,  0, 1, 0, 0, X_IDLE,  0), "key_st3");

        // reset in the middle of a stall, with the FIFO clearing on the same cycle
        apply(row(0, 1, 4'd11, 0, 32'h0, 1, 1, 0, 0, X_IDLE,  0), "rst_st0");
        apply(row(0, 0, 4'd0,  0, 32'h0, 1, 1, 0, 0, X_STALL, 0), "rst_st1");
        apply(row(1, 0, 4'd0,  0, 32'h0, 0, 1, 0, 0, X_STALL, 0), "rst_st2");
        apply(row(0, 1, 4'd0,  0, 32'h0, 0, 1, 0, 0, X_IDLE,  0), "rst_st3");
        apply(row(0, 1, 4'd0,  0, 32'h0, 0, 1, 0, 0, X_IDLE,  0), "rst_st4");

        chk("rcv_sb_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
